// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package mips_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] PC_INC           = 32'd4;
  localparam logic [WORD_W-1:0] NOP              = 32'h0000_0000;
  localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] ins;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  // Fetch addresses are always word aligned; the low two bits are dropped.
  function automatic logic [WORD_W-1:0] align_pc(input logic [WORD_W-1:0] pc);
    return pc & ~32'h3;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO with flush; push and pop in one cycle are both honoured.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full buffer is legal only when the head leaves in the same cycle.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC/credit/drop bookkeeping around an in-order response queue.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins,
  output logic [31:0] ins_pc
);

  localparam int CW  = $clog2(DEPTH + 1);
  localparam int CW1 = CW + 1;
  localparam logic [CW:0] CREDITS = CW1'(DEPTH);

  logic [31:0]        fetch_pc;
  logic [31:0]        rsp_pc;
  logic [31:0]        last_pc;
  logic [CW-1:0]      outstanding;
  logic [CW-1:0]      drop_cnt;
  logic [CW-1:0]      count;
  logic [CW:0]        credit_used;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] head_raw;
  entry_t             head;
  entry_t             push_entry;
  logic               req_fire;
  logic               rsp_drop;
  logic               rsp_keep;
  logic               pop;

  // Both channels transfer on a rising edge where valid && ready; valid never waits on ready.
  assign credit_used    = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = !rst && !redirect_valid && (credit_used < CREDITS);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop   = imem_rsp_valid && (redirect_valid || (drop_cnt != '0));
  assign rsp_keep   = imem_rsp_valid && !rsp_drop;
  assign pop        = ins_valid && ins_ready;
  assign push_entry = {rsp_pc, imem_rsp_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      last_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      last_pc <= ins_pc;
      if (redirect_valid) begin
        fetch_pc    <= align_pc(redirect_pc);
        rsp_pc      <= align_pc(redirect_pc);
        // Every request still in flight belongs to the abandoned path.
        outstanding <= outstanding - CW'(imem_rsp_valid);
        drop_cnt    <= outstanding - CW'(imem_rsp_valid);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + PC_INC;
        if (rsp_keep) rsp_pc   <= rsp_pc + PC_INC;
        if (rsp_drop) drop_cnt <= drop_cnt - 1'b1;
        if (req_fire && !imem_rsp_valid)      outstanding <= outstanding + 1'b1;
        else if (!req_fire && imem_rsp_valid) outstanding <= outstanding - 1'b1;
      end
    end
  end

  sync_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_keep),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (push_entry),
    .rdata (head_raw),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  assign head      = entry_t'(head_raw);
  assign ins_valid = !fifo_empty;
  assign ins       = fifo_empty ? NOP : head.ins;
  assign ins_pc    = fifo_empty ? last_pc : head.pc;

  // Credits guarantee a kept response always has room.
  assert property (@(posedge clk) disable iff (rst) rsp_keep |-> (!fifo_full || pop));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed scoreboard bench for fetch_stage with a variable-latency memory model.
module tb_fetch_stage;
  import mips_pkg::*;

  localparam logic [31:0] HI_RESET_PC = 32'hFFFF_FFF8;
  localparam logic [31:0] DATA_MASK   = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ins_valid, ins_ready;
  logic [31:0] ins, ins_pc;

  logic        imem_req_valid_b, imem_req_ready_b;
  logic [31:0] imem_req_addr_b;
  logic        imem_rsp_valid_b;
  logic [31:0] imem_rsp_data_b;
  logic        redirect_valid_b;
  logic [31:0] redirect_pc_b;
  logic        ins_valid_b, ins_ready_b;
  logic [31:0] ins_b, ins_pc_b;

  int total = 0;
  int bad = 0;
  int lat = 1;
  int cyc = 0;
  int req_count = 0;
  int pop_count = 0;
  int first_pop = 0;
  int last_pop = 0;

  logic [63:0] exp_q[$];
  logic [63:0] exp_b_q[$];
  logic [31:0] pend_addr_q[$];
  int          pend_due_q[$];

  fetch_stage u_dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ins_valid      (ins_valid),
    .ins_ready      (ins_ready),
    .ins            (ins),
    .ins_pc         (ins_pc)
  );

  fetch_stage #(.RESET_PC(HI_RESET_PC), .DEPTH(4)) u_dut_hi (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid_b),
    .imem_req_ready (imem_req_ready_b),
    .imem_req_addr  (imem_req_addr_b),
    .imem_rsp_valid (imem_rsp_valid_b),
    .imem_rsp_data  (imem_rsp_data_b),
    .redirect_valid (redirect_valid_b),
    .redirect_pc    (redirect_pc_b),
    .ins_valid      (ins_valid_b),
    .ins_ready      (ins_ready_b),
    .ins            (ins_b),
    .ins_pc         (ins_pc_b)
  );

  // clock / reset block
  initial forever #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // memory models: responses in request order, one per cycle, cleared by rst
  initial begin
    logic        fire_b_prev;
    logic [31:0] addr_b_prev;
    fire_b_prev = 1'b0;
    addr_b_prev = '0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    imem_rsp_valid_b = 1'b0;
    imem_rsp_data_b = '0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      imem_rsp_valid = 1'b0;
      imem_rsp_data = '0;
      imem_rsp_valid_b = 1'b0;
      imem_rsp_data_b = '0;
      if (rst) begin
        pend_addr_q.delete();
        pend_due_q.delete();
        fire_b_prev = 1'b0;
      end else begin
        if (pend_due_q.size() > 0 && pend_due_q[0] <= cyc) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data = pend_addr_q[0] ^ DATA_MASK;
          void'(pend_addr_q.pop_front());
          void'(pend_due_q.pop_front());
        end
        if (imem_req_valid && imem_req_ready) begin
          pend_addr_q.push_back(imem_req_addr);
          pend_due_q.push_back(cyc + lat);
          req_count++;
        end
        imem_rsp_valid_b = fire_b_prev;
        imem_rsp_data_b = addr_b_prev ^ DATA_MASK;
        fire_b_prev = imem_req_valid_b && imem_req_ready_b;
        addr_b_prev = imem_req_addr_b;
      end
    end
  end

  // scoreboard monitor
  initial begin
    logic [63:0] exp_e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && ins_valid && ins_ready) begin
        if (pop_count == 0) first_pop = cyc;
        last_pop = cyc;
        pop_count++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL ins_unexpected: got pc=%h ins=%h, required no transfer", ins_pc, ins);
        end else begin
          exp_e = exp_q.pop_front();
          if ({ins_pc, ins} !== exp_e) begin
            bad++;
            $display("FAIL ins_seq: got pc=%h ins=%h, required pc=%h ins=%h",
                     ins_pc, ins, exp_e[63:32], exp_e[31:0]);
          end
        end
      end
      if (!rst && ins_valid_b && ins_ready_b) begin
        total++;
        if (exp_b_q.size() == 0) begin
          bad++;
          $display("FAIL ins_hi_unexpected: got pc=%h ins=%h, required no transfer", ins_pc_b, ins_b);
        end else begin
          exp_e = exp_b_q.pop_front();
          if ({ins_pc_b, ins_b} !== exp_e) begin
            bad++;
            $display("FAIL ins_hi_seq: got pc=%h ins=%h, required pc=%h ins=%h",
                     ins_pc_b, ins_b, exp_e[63:32], exp_e[31:0]);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %b, required %b", name, got, want);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_q.push_back({pc, pc ^ DATA_MASK});
  endtask

  task automatic push_exp_b(input logic [31:0] pc);
    exp_b_q.push_back({pc, pc ^ DATA_MASK});
  endtask

  // Leaves the caller at a negedge with rst still high; clearing rst there starts window 0.
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    ins_ready = 1'b0;
    ins_ready_b = 1'b0;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    @(negedge clk);
    pop_count = 0;
  endtask

  task automatic drain(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && exp_b_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    ins_ready = 1'b0;
    ins_ready_b = 1'b0;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s_drain: got %0d entries left, required 0", name, exp_q.size() + exp_b_q.size());
      exp_q.delete();
      exp_b_q.delete();
    end
  endtask

  // stimulus
  initial begin
    ins_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    imem_req_ready = 1'b1;
    ins_ready_b = 1'b0;
    redirect_valid_b = 1'b0;
    redirect_pc_b = '0;
    imem_req_ready_b = 1'b1;

    // reset state
    apply_reset();
    #3;
    check1("rst_ins_valid", ins_valid, 1'b0);
    check1("rst_req_valid", imem_req_valid, 1'b0);
    check32("rst_ins", ins, 32'h0);
    check32("rst_ins_pc", ins_pc, 32'h0);
    check32("rst_hi_ins_pc", ins_pc_b, HI_RESET_PC);
    check1("rst_hi_req_valid", imem_req_valid_b, 1'b0);

    // 1: streaming with a 1-cycle memory
    apply_reset();
    lat = 1;
    for (int i = 0; i < 8; i++) push_exp(32'(i * 4));
    rst = 1'b0;
    ins_ready = 1'b1;
    #3;
    check1("t1_req_valid_w0", imem_req_valid, 1'b1);
    check32("t1_req_addr_w0", imem_req_addr, 32'h0);
    check1("t1_ins_valid_w0", ins_valid, 1'b0);
    @(negedge clk);
    #3;
    check1("t1_ins_valid_w1", ins_valid, 1'b0);
    check32("t1_req_addr_w1", imem_req_addr, 32'h4);
    @(negedge clk);
    #3;
    check1("t1_ins_valid_w2", ins_valid, 1'b1);
    drain("t1", 40);
    check32("t1_pop_count", 32'(pop_count), 32'd8);
    check32("t1_rate", 32'(last_pop - first_pop), 32'd7);

    // 2: consumer stall, credit limit, release
    apply_reset();
    lat = 1;
    req_count = 0;
    rst = 1'b0;
    ins_ready = 1'b0;
    repeat (9) @(negedge clk);
    #3;
    check32("t2_req_count", 32'(req_count), 32'd4);
    check1("t2_req_stopped", imem_req_valid, 1'b0);
    check1("t2_head_valid", ins_valid, 1'b1);
    check32("t2_head_pc", ins_pc, 32'h0);
    for (int i = 0; i < 8; i++) push_exp(32'(i * 4));
    @(negedge clk);
    ins_ready = 1'b1;
    pop_count = 0;
    @(negedge clk);
    #3;
    check1("t2_resume_valid", imem_req_valid, 1'b1);
    check32("t2_resume_addr", imem_req_addr, 32'h10);
    drain("t2", 40);
    check32("t2_pop_count", 32'(pop_count), 32'd8);
    check32("t2_rate", 32'(last_pop - first_pop), 32'd7);

    // 3: redirect with three stale requests in flight, 3-cycle memory
    apply_reset();
    lat = 3;
    for (int i = 0; i < 4; i++) push_exp(32'h400 + 32'(i * 4));
    rst = 1'b0;
    ins_ready = 1'b1;
    repeat (3) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0403;
    #3;
    check1("t3_no_req_in_redirect", imem_req_valid, 1'b0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #3;
    check1("t3_new_req_valid", imem_req_valid, 1'b1);
    check32("t3_new_req_addr", imem_req_addr, 32'h400);
    check1("t3_flushed", ins_valid, 1'b0);
    drain("t3", 60);

    // 4: redirect coinciding with a response and a pop, 2-cycle memory
    apply_reset();
    lat = 2;
    push_exp(32'h0);
    push_exp(32'h4);
    push_exp(32'h300);
    push_exp(32'h304);
    push_exp(32'h308);
    rst = 1'b0;
    ins_ready = 1'b1;
    repeat (4) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0300;
    #3;
    check1("t4_pop_valid_in_redirect", ins_valid, 1'b1);
    check32("t4_pop_pc_in_redirect", ins_pc, 32'h4);
    check1("t4_no_req_in_redirect", imem_req_valid, 1'b0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #3;
    check1("t4_flushed", ins_valid, 1'b0);
    check1("t4_new_req_valid", imem_req_valid, 1'b1);
    check32("t4_new_req_addr", imem_req_addr, 32'h300);
    drain("t4", 60);

    // 5: PC wrap from a high reset vector
    apply_reset();
    lat = 1;
    push_exp_b(32'hFFFF_FFF8);
    push_exp_b(32'hFFFF_FFFC);
    push_exp_b(32'h0000_0000);
    push_exp_b(32'h0000_0004);
    rst = 1'b0;
    ins_ready_b = 1'b1;
    #3;
    check32("t5_first_addr", imem_req_addr_b, 32'hFFFF_FFF8);
    drain("t5", 40);

    // 6: reset with a partly full queue and two requests in flight
    apply_reset();
    lat = 3;
    rst = 1'b0;
    ins_ready = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #3;
    check1("t6_req_valid_in_rst", imem_req_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    ins_ready = 1'b1;
    push_exp(32'h0);
    push_exp(32'h4);
    push_exp(32'h8);
    #3;
    check1("t6_ins_valid", ins_valid, 1'b0);
    check32("t6_ins", ins, 32'h0);
    check32("t6_ins_pc", ins_pc, 32'h0);
    check1("t6_req_valid", imem_req_valid, 1'b1);
    check32("t6_req_addr", imem_req_addr, 32'h0);
    check32("t6_hi_ins_pc", ins_pc_b, HI_RESET_PC);
    drain("t6", 60);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
